// File: rtl/enemy_fleet_ctrl.sv
// enemy_fleet_ctrl: marches the enemy fleet side to side, drops it at each bound,
// and reports wave-cleared / fleet-landed status on frame ticks.
module enemy_fleet_ctrl #(
    parameter logic [9:0] LEFT_BOUND  = 10'd8,
    parameter logic [9:0] RIGHT_BOUND = 10'd631,
    parameter logic [9:0] LAND_Y      = 10'd440,
    parameter logic [3:0] DROP_FRAMES = 4'd8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic [9:0] fleet_left_x,
    input  logic [9:0] fleet_right_x,
    input  logic [9:0] fleet_bottom_y,
    input  logic [5:0] alive_count,
    output logic       enemy_direction_X,
    output logic       enemy_direction_Y,
    output logic       delete_enemies,
    output logic       wave_cleared,
    output logic       fleet_landed,
    output logic [3:0] wave_num
);
    typedef enum logic [2:0] {IDLE, MARCH_R, DROP_R, MARCH_L, DROP_L, CLEARED, LANDED} state_t;
    state_t     state_q, state_d;
    logic       frame_clk_d_q, frame_clk_d_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic       delete_q, delete_d, cleared_q, cleared_d, landed_q, landed_d;
    logic [3:0] wave_num_q, wave_num_d, drop_cnt_q, drop_cnt_d;
    logic       tick, parked, dropping;
    assign tick     = frame_clk & ~frame_clk_d_q;
    assign parked   = (state_q == IDLE) || (state_q == CLEARED) || (state_q == LANDED);
    assign dropping = (state_q == DROP_R) || (state_q == DROP_L);
    always_comb begin
        state_d       = state_q;
        frame_clk_d_d = frame_clk;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        delete_d      = delete_q;
        cleared_d     = cleared_q;
        landed_d      = landed_q;
        wave_num_d    = wave_num_q;
        drop_cnt_d    = drop_cnt_q;
        if (parked) begin
            if (start) begin
                state_d   = MARCH_R;
                dir_x_d   = 1'b1;
                dir_y_d   = 1'b0;
                delete_d  = 1'b0;
                cleared_d = 1'b0;
                landed_d  = 1'b0;
            end
        end else if (tick) begin
            if (alive_count == 6'd0) begin
                state_d    = CLEARED;
                cleared_d  = 1'b1;
                dir_y_d    = 1'b0;
                wave_num_d = (wave_num_q == 4'd15) ? wave_num_q : wave_num_q + 4'd1;
            end else if (fleet_bottom_y >= LAND_Y) begin
                state_d  = LANDED;
                landed_d = 1'b1;
                delete_d = 1'b1;
                dir_y_d  = 1'b0;
            end else if (dropping) begin
                // bounds are not tested here, so a fleet still past a bound cannot re-reverse
                drop_cnt_d = drop_cnt_q - 4'd1;
                if (drop_cnt_q == 4'd1) begin
                    dir_y_d = 1'b0;
                    state_d = (state_q == DROP_R) ? MARCH_L : MARCH_R;
                end
            end else if (state_q == MARCH_R && fleet_right_x >= RIGHT_BOUND) begin
                state_d    = DROP_R;
                dir_x_d    = 1'b0;
                dir_y_d    = 1'b1;
                drop_cnt_d = DROP_FRAMES;
            end else if (state_q == MARCH_L && fleet_left_x <= LEFT_BOUND) begin
                state_d    = DROP_L;
                dir_x_d    = 1'b1;
                dir_y_d    = 1'b1;
                drop_cnt_d = DROP_FRAMES;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            frame_clk_d_q <= 1'b0;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b0;
            delete_q      <= 1'b0;
            cleared_q     <= 1'b0;
            landed_q      <= 1'b0;
            wave_num_q    <= 4'd0;
            drop_cnt_q    <= 4'd0;
        end else begin
            state_q       <= state_d;
            frame_clk_d_q <= frame_clk_d_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            delete_q      <= delete_d;
            cleared_q     <= cleared_d;
            landed_q      <= landed_d;
            wave_num_q    <= wave_num_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end
    assign enemy_direction_X = dir_x_q;
    assign enemy_direction_Y = dir_y_q;
    assign delete_enemies    = delete_q;
    assign wave_cleared      = cleared_q;
    assign fleet_landed      = landed_q;
    assign wave_num          = wave_num_q;
endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// tb_enemy_fleet_ctrl: directed scenarios plus randomized frames for enemy_fleet_ctrl,
// checked against a behavioural fleet model.
module tb_enemy_fleet_ctrl;
    logic       Clk = 1'b0;
    logic       Reset, frame_clk, start;
    logic [9:0] lx, rx, by;
    logic [5:0] alive;
    logic       dx, dy, del, clr, land;
    logic [3:0] wave;
    int         total = 0, bad = 0;
    bit         m_act, m_dx, m_dy, m_del, m_clr, m_land, m_prev;
    int         m_drop, m_wave;

    enemy_fleet_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .fleet_left_x(lx), .fleet_right_x(rx), .fleet_bottom_y(by), .alive_count(alive),
        .enemy_direction_X(dx), .enemy_direction_Y(dy), .delete_enemies(del),
        .wave_cleared(clr), .fleet_landed(land), .wave_num(wave)
    );

    always #5 Clk = ~Clk;

    function automatic logic [8:0] got_vec();
        return {dx, dy, del, clr, land, wave};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_dx, m_dy, m_del, m_clr, m_land, 4'(m_wave)};
    endfunction

    // Model: a wave is either active or parked; an active wave is dropping while m_drop > 0,
    // otherwise marching in direction m_dx.
    task automatic cyc(input bit fr, input bit st, input bit rs);
        bit tk;
        frame_clk = fr; start = st; Reset = rs;
        @(posedge Clk);
        if (rs) begin
            m_act = 0; m_drop = 0; m_dx = 1; m_dy = 0; m_del = 0; m_clr = 0; m_land = 0; m_wave = 0; m_prev = 0;
        end else begin
            tk = fr && !m_prev;
            m_prev = fr;
            if (!m_act) begin
                if (st) begin
                    m_act = 1; m_drop = 0; m_dx = 1; m_dy = 0; m_del = 0; m_clr = 0; m_land = 0;
                end
            end else if (tk) begin
                if (alive == 0) begin
                    m_act = 0; m_clr = 1; m_dy = 0; m_wave = (m_wave < 15) ? m_wave + 1 : 15;
                end else if (by >= 440) begin
                    m_act = 0; m_land = 1; m_del = 1; m_dy = 0;
                end else if (m_drop > 0) begin
                    m_drop--;
                    if (m_drop == 0) m_dy = 0;
                end else if (m_dx && rx >= 631) begin
                    m_dx = 0; m_dy = 1; m_drop = 8;
                end else if (!m_dx && lx <= 8) begin
                    m_dx = 1; m_dy = 1; m_drop = 8;
                end
            end
        end
        #1;
    endtask

    task automatic tick1();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
    endtask

    task automatic test_reset();
        lx = 10'd300; rx = 10'd400; by = 10'd100; alive = 6'd40;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        total++;
        if (got_vec() !== 9'b1_0_0_0_0_0000) begin
            bad++; $display("FAIL reset got=%b exp=%b", got_vec(), 9'b1_0_0_0_0_0000);
        end
        tick1(); tick1();
        total++;
        if (got_vec() !== exp_vec() || got_vec() !== 9'b1_0_0_0_0_0000) begin
            bad++; $display("FAIL idle_tick got=%b exp=%b", got_vec(), exp_vec());
        end
    endtask

    task automatic test_march_right();
        cyc(0, 1, 0);
        total++;
        if (dx !== 1'b1 || dy !== 1'b0) begin
            bad++; $display("FAIL start got dx=%b dy=%b exp dx=1 dy=0", dx, dy);
        end
        for (int i = 0; i <= 10; i++) begin
            rx = 10'(621 + i);
            cyc(1, 0, 0);
            total++;
            if (got_vec() !== exp_vec() || {dx, dy} !== ((i == 10) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL ramp_r i=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
            cyc(0, 0, 0);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 0);
            total++;
            if (got_vec() !== exp_vec() || dy !== (k < 8) || dx !== 1'b0) begin
                bad++; $display("FAIL drop_r k=%0d got dx=%b dy=%b exp dx=0 dy=%b", k, dx, dy, k < 8);
            end
            cyc(0, 0, 0);
        end
    endtask

    task automatic test_march_left();
        rx = 10'd300; lx = 10'd8;
        for (int k = 0; k <= 9; k++) begin
            cyc(1, 0, 0);
            total++;
            if (got_vec() !== exp_vec() || dx !== 1'b1 || dy !== (k < 8)) begin
                bad++; $display("FAIL drop_l k=%0d got dx=%b dy=%b exp dx=1 dy=%b", k, dx, dy, k < 8);
            end
            cyc(0, 0, 0);
        end
    endtask

    task automatic test_clear();
        alive = 6'd0; by = 10'd450;
        tick1();
        total++;
        if ({clr, land, del, dy, wave} !== 8'b1_0_0_0_0001 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL clear got=%b exp=%b", got_vec(), exp_vec());
        end
        tick1();
        total++;
        if (wave !== 4'd1 || clr !== 1'b1) begin
            bad++; $display("FAIL clear_hold got wave=%0d clr=%b exp wave=1 clr=1", wave, clr);
        end
        for (int i = 2; i <= 17; i++) begin
            cyc(0, 1, 0);
            tick1();
        end
        total++;
        if (wave !== 4'd15 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL wave_sat got wave=%0d exp wave=15", wave);
        end
    endtask

    task automatic test_land_mid_drop();
        alive = 6'd5; by = 10'd100; rx = 10'd631; lx = 10'd300;
        cyc(0, 1, 0);
        tick1(); tick1(); tick1();
        total++;
        if (dy !== 1'b1 || dx !== 1'b0) begin
            bad++; $display("FAIL mid_drop got dx=%b dy=%b exp dx=0 dy=1", dx, dy);
        end
        by = 10'd440;
        tick1();
        total++;
        if ({land, del, dy, clr} !== 4'b1100 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL land got=%b exp=%b", got_vec(), exp_vec());
        end
        by = 10'd100;
        cyc(0, 1, 0);
        total++;
        if ({land, del, clr, dx, dy} !== 5'b00010 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL restart got=%b exp=%b", got_vec(), exp_vec());
        end
    endtask

    task automatic test_hold_and_reset();
        rx = 10'd700;
        for (int i = 0; i < 100; i++) cyc(1, 0, 0);
        total++;
        if (dy !== 1'b1 || dx !== 1'b0 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL hold_high got dx=%b dy=%b exp dx=0 dy=1", dx, dy);
        end
        cyc(0, 0, 0);
        for (int i = 0; i < 5; i++) tick1();
        total++;
        if (dy !== 1'b1 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL cnt3 got dy=%b exp dy=1", dy);
        end
        cyc(1, 1, 1);
        total++;
        if (got_vec() !== 9'b1_0_0_0_0_0000) begin
            bad++; $display("FAIL reset_drop got=%b exp=%b", got_vec(), 9'b1_0_0_0_0_0000);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_start_mid_march();
        rx = 10'd631; lx = 10'd300;
        cyc(0, 1, 0);
        for (int i = 0; i < 9; i++) tick1();
        rx = 10'd300;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        total++;
        if ({dx, dy, clr, land} !== 4'b0000 || got_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_ignored got=%b exp=%b", got_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit fr = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2) == 0) fr = ~fr;
            alive = ($urandom_range(29) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
            by    = ($urandom_range(39) == 0) ? 10'($urandom_range(460, 440)) : 10'($urandom_range(439));
            lx    = 10'($urandom_range(20));
            rx    = 10'($urandom_range(640, 620));
            cyc(fr, $urandom_range(19) == 0, $urandom_range(299) == 0);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; start = 1'b0;
        lx = '0; rx = '0; by = '0; alive = '0;
        m_prev = 0;
        test_reset();
        test_march_right();
        test_march_left();
        test_clear();
        test_land_mid_drop();
        test_hold_and_reset();
        test_start_mid_march();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enemy_fleet_ctrl.md
ENEMY_FLEET_CTRL -- requirements
Module: enemy_fleet_ctrl

Interface
REQ-001 Parameter LEFT_BOUND, 10'd8, fleet reverses to the right when fleet_left_x <= LEFT_BOUND.
REQ-002 Parameter RIGHT_BOUND, 10'd631, fleet reverses to the left when fleet_right_x >= RIGHT_BOUND.
REQ-003 Parameter LAND_Y, 10'd440, fleet has landed when fleet_bottom_y >= LAND_Y.
REQ-004 Parameter DROP_FRAMES, 4'd8, number of frame ticks enemy_direction_Y stays high per reversal.
REQ-005 Clk  input  1  system clock; all logic on posedge Clk.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 frame_clk  input  1  frame-rate strobe level, synchronous to Clk; rising edge is one frame tick.
REQ-008 start  input  1  begin a wave; honoured only in IDLE, CLEARED, LANDED.
REQ-009 fleet_left_x / fleet_right_x / fleet_bottom_y  input  10 each  extents of live enemies, pixels.
REQ-010 alive_count  input  6  number of live enemies.
REQ-011 enemy_direction_X  output  1  0 = move left, 1 = move right; fanned out to every enemy instance.
REQ-012 enemy_direction_Y  output  1  1 = move down one step per frame.
REQ-013 delete_enemies  output  1  forces every enemy to its finished state.
REQ-014 wave_cleared / fleet_landed  output  1 each  status flags.
REQ-015 wave_num  output  4  count of cleared waves.

Function
REQ-016 Frame tick SHALL be frame_clk & ~frame_clk_d, with frame_clk_d a Clk-registered copy; all movement decisions occur only on tick cycles.
REQ-017 Registered outputs SHALL update on the Clk edge after the tick cycle, so they are stable before the next frame_clk rising edge.
REQ-018 States SHALL be IDLE, MARCH_R, DROP_R, MARCH_L, DROP_L, CLEARED, LANDED.
REQ-019 IDLE/CLEARED/LANDED + start=1 -> MARCH_R; set direction_X=1, direction_Y=0, delete_enemies=0, wave_cleared=0, fleet_landed=0.
REQ-020 MARCH_R, tick, fleet_right_x >= RIGHT_BOUND -> DROP_R; set direction_X=0, direction_Y=1, drop_cnt=DROP_FRAMES.
REQ-021 MARCH_L, tick, fleet_left_x <= LEFT_BOUND -> DROP_L; set direction_X=1, direction_Y=1, drop_cnt=DROP_FRAMES.
REQ-022 DROP_x, tick: drop_cnt decrements; when drop_cnt==1 on the tick, set direction_Y=0 and go to MARCH_L (from DROP_R) or MARCH_R (from DROP_L); direction_Y is high for exactly DROP_FRAMES ticks.
REQ-023 Boundary tests SHALL not run in DROP states, so no re-reversal while the fleet is still past a bound.
REQ-024 Any march/drop state, tick, alive_count==0 -> CLEARED; wave_cleared=1, direction_Y=0, wave_num increments, saturating at 15.
REQ-025 Any march/drop state, tick, alive_count!=0 and fleet_bottom_y >= LAND_Y -> LANDED; fleet_landed=1, delete_enemies=1, direction_Y=0.
REQ-026 Priority on a single tick SHALL be: cleared > landed > drop countdown > boundary reversal.
REQ-027 Flags and delete_enemies SHALL hold their values until the next accepted start or Reset; start SHALL be ignored during march/drop states.
REQ-028 A start coinciding with a tick in IDLE/CLEARED/LANDED SHALL take the start path; the tick is discarded.
REQ-029 Comparisons SHALL be unsigned 10-bit, and drop_cnt SHALL be 4 bits.

Reset
REQ-030 On Reset=1 at a Clk edge, the block SHALL set state=IDLE, direction_X=1, direction_Y=0, delete_enemies=0, wave_cleared=0, fleet_landed=0, wave_num=0, drop_cnt=0, frame_clk_d=0, regardless of current state.
REQ-031 Reset SHALL take priority over start and tick in the same cycle; ticks in IDLE have no effect.

Verification
REQ-032 Reset, start, alive=40, right_x ramps to 631 on tick N -> direction_X=0 and direction_Y=1 one Clk after tick N; direction_Y stays high for exactly 8 ticks; state then MARCH_L.
REQ-033 In MARCH_L, left_x=8 on a tick -> direction_X=1, direction_Y=1 for 8 ticks, then MARCH_R; left_x=8 held during the drop causes no extra reversal.
REQ-034 alive_count=0 and bottom_y=450 on the same tick -> wave_cleared=1, fleet_landed=0, wave_num 0->1; 16 clears leave wave_num=15.
REQ-035 alive=5, bottom_y=440 on a tick mid-drop -> fleet_landed=1, delete_enemies=1, direction_Y=0; next start clears all three flags, direction_X=1.
REQ-036 frame_clk held high 100 Clks -> exactly one tick; Reset asserted in DROP_R with drop_cnt=3 -> all outputs at reset values on the next edge; start mid-march -> no state change.
